// File: rtl/piano_pkg.sv
// Shared constants for the piano message stream and a rank-width helper
// used by the voice allocator and its LRU rank table.
package piano_pkg;

  localparam int NOTE_W_DEFAULT = 7;
  localparam int MSG_ON = NOTE_W_DEFAULT;
  localparam logic [NOTE_W_DEFAULT-1:0] ALL_OFF = '1;

  function automatic int rank_w(input int voices);
    return (voices < 2) ? 1 : $clog2(voices);
  endfunction

endpackage

// File: rtl/voice_rank_table.sv
// LRU permutation over voice slots (rank 0 = newest) with promote/demote
// updates, held-count, and lookups for the free slot, steal victim and newest.
module voice_rank_table import piano_pkg::*; #(
  parameter int VOICES = 4,
  localparam int RW = rank_w(VOICES)
) (
  input  logic              clk_msg,
  input  logic              rst,
  input  logic [VOICES-1:0] held,
  input  logic              promote,
  input  logic              demote,
  input  logic [RW-1:0]     sel,
  output logic [RW:0]       held_cnt,
  output logic [RW-1:0]     free_voice,
  output logic [RW-1:0]     victim_voice,
  output logic [RW-1:0]     newest_voice
);

  logic [RW-1:0] rank_q [VOICES];

  always_ff @(posedge clk_msg or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < VOICES; i++) rank_q[i] <= RW'(i);
    end else if (promote) begin
      for (int i = 0; i < VOICES; i++) begin
        if (RW'(i) == sel)              rank_q[i] <= '0;
        else if (rank_q[i] < rank_q[sel]) rank_q[i] <= rank_q[i] + 1'b1;
      end
    end else if (demote) begin
      for (int i = 0; i < VOICES; i++) begin
        if (RW'(i) == sel)              rank_q[i] <= RW'(VOICES - 1);
        else if (rank_q[i] > rank_q[sel]) rank_q[i] <= rank_q[i] - 1'b1;
      end
    end
  end

  always_comb begin
    held_cnt = '0;
    for (int i = 0; i < VOICES; i++) held_cnt = held_cnt + (RW+1)'(held[i]);
  end

  // Held voices occupy ranks 0..k-1, so rank k is the newest free slot.
  always_comb begin
    free_voice   = '0;
    victim_voice = '0;
    newest_voice = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (rank_q[i] == held_cnt[RW-1:0])  free_voice   = RW'(i);
      if (rank_q[i] == RW'(VOICES - 1))   victim_voice = RW'(i);
      if (rank_q[i] == '0)                newest_voice = RW'(i);
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic note tracker: matches note messages against held voices,
// allocates or steals slots via the rank table, and masks outputs for mono mode.
module voice_alloc import piano_pkg::*; #(
  parameter int VOICES  = 4,
  parameter int NOTE_W  = NOTE_W_DEFAULT,
  parameter int STEAL_W = 8
) (
  input  logic                     clk_msg,
  input  logic                     rst,
  input  logic [NOTE_W:0]          msg,
  input  logic                     mode,
  output logic [VOICES*NOTE_W-1:0] voice_note,
  output logic [VOICES-1:0]        voice_active,
  output logic [NOTE_W-1:0]        disp_note,
  output logic [STEAL_W-1:0]       steal_cnt
);

  localparam int RW = rank_w(VOICES);
  localparam logic [NOTE_W-1:0] ALL_OFF_ID = '1;

  logic [NOTE_W-1:0]  note_q [VOICES];
  logic [VOICES-1:0]  held_q;
  logic [STEAL_W-1:0] steal_q;

  logic              msg_on, is_all_off, hit, table_full, any_held;
  logic [NOTE_W-1:0] msg_id;
  logic [RW-1:0]     hit_v, sel, free_voice, victim_voice, newest_voice;
  logic [RW:0]       held_cnt;
  logic              promote, demote, wr_en, do_steal, clear_all;

  assign msg_on     = msg[NOTE_W];
  assign msg_id     = msg[NOTE_W-1:0];
  assign is_all_off = (msg_id == ALL_OFF_ID);
  assign table_full = (held_cnt == (RW+1)'(VOICES));
  assign any_held   = |held_q;

  always_comb begin
    hit   = 1'b0;
    hit_v = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (held_q[i] && note_q[i] == msg_id) begin
        hit   = 1'b1;
        hit_v = RW'(i);
      end
    end
  end

  // Match check comes first, so a held note is refreshed, never duplicated.
  always_comb begin
    promote   = 1'b0;
    demote    = 1'b0;
    wr_en     = 1'b0;
    do_steal  = 1'b0;
    clear_all = 1'b0;
    sel       = hit_v;
    if (msg_on && !is_all_off) begin
      promote = 1'b1;
      if (!hit) begin
        wr_en    = 1'b1;
        sel      = table_full ? victim_voice : free_voice;
        do_steal = table_full;
      end
    end else if (!msg_on) begin
      if (is_all_off) clear_all = 1'b1;
      else if (hit)   demote    = 1'b1;
    end
  end

  voice_rank_table #(.VOICES(VOICES)) u_rank (
    .clk_msg      (clk_msg),
    .rst          (rst),
    .held         (held_q),
    .promote      (promote),
    .demote       (demote),
    .sel          (sel),
    .held_cnt     (held_cnt),
    .free_voice   (free_voice),
    .victim_voice (victim_voice),
    .newest_voice (newest_voice)
  );

  always_ff @(posedge clk_msg or posedge rst) begin
    if (rst) begin
      held_q  <= '0;
      steal_q <= '0;
      for (int i = 0; i < VOICES; i++) note_q[i] <= '0;
    end else begin
      if (clear_all)   held_q      <= '0;
      else if (wr_en)  held_q[sel] <= 1'b1;
      else if (demote) held_q[sel] <= 1'b0;
      if (wr_en) note_q[sel] <= msg_id;
      if (do_steal && steal_q != '1) steal_q <= steal_q + 1'b1;
    end
  end

  always_comb begin
    voice_note = '0;
    for (int i = 0; i < VOICES; i++) voice_note[i*NOTE_W +: NOTE_W] = note_q[i];
  end

  // Mono masking only touches the outputs; the table keeps tracking every key.
  assign voice_active = !mode    ? held_q :
                        any_held ? (VOICES'(1) << newest_voice) : '0;
  assign disp_note    = any_held ? note_q[newest_voice] : '0;
  assign steal_cnt    = steal_q;

endmodule
